// File: rtl/lab1_imul_mul_arbiter_pkg.sv
// ============================================================================
// Module  : lab1_imul_mul_arbiter_pkg
// Brief   : Shared types and FSM encoding for the two-port multiplier arbiter
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lab1_imul_mul_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_SEND = 2'd1;
    localparam state_t c_ST_WAIT = 2'd2;
    localparam state_t c_ST_RESP = 2'd3;

    // Message formats at the default 32-bit width
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } lab1_imul_req_msg_t;

    typedef logic [31:0] lab1_imul_resp_msg_t;

endpackage

`default_nettype wire

// File: rtl/lab1_imul_rr_arb2.sv
// ============================================================================
// Module  : lab1_imul_rr_arb2
// Brief   : Combinational 2-way round-robin grant; ptr names the favoured port
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lab1_imul_rr_arb2
    import lab1_imul_mul_arbiter_pkg::*;
(
    input  logic [1:0] val,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = ptr;
        if (val == 2'b01) begin
            winner = 1'b0;
        end else if (val == 2'b10) begin
            winner = 1'b1;
        end
        grant = 2'b00;
        if (val != 2'b00) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lab1_imul_mul_arbiter.sv
// ============================================================================
// Module  : lab1_imul_mul_arbiter
// Brief   : Shares one variable-latency multiplier between two val/rdy ports
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lab1_imul_mul_arbiter
    import lab1_imul_mul_arbiter_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_val,
    output logic                 req0_rdy,
    input  logic [2*p_nbits-1:0] req0_msg,
    output logic                 resp0_val,
    input  logic                 resp0_rdy,
    output logic [p_nbits-1:0]   resp0_msg,

    input  logic                 req1_val,
    output logic                 req1_rdy,
    input  logic [2*p_nbits-1:0] req1_msg,
    output logic                 resp1_val,
    input  logic                 resp1_rdy,
    output logic [p_nbits-1:0]   resp1_msg,

    output logic                 mul_req_val,
    input  logic                 mul_req_rdy,
    output logic [2*p_nbits-1:0] mul_req_msg,
    input  logic                 mul_resp_val,
    output logic                 mul_resp_rdy,
    input  logic [p_nbits-1:0]   mul_resp_msg,

    output logic                 busy
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_ptr;
    logic                 r_owner;
    logic [2*p_nbits-1:0] r_operand;
    logic [p_nbits-1:0]   r_result;
    logic [1:0]           w_grant;
    logic                 w_winner;
    logic                 w_accept;

    lab1_imul_rr_arb2 u_arb (
        .val    ({req1_val, req0_val}),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .winner (w_winner)
    );

    assign w_accept = (r_state == c_ST_IDLE) && (w_grant != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_operand <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_operand <= w_winner ? req1_msg : req0_msg;
                r_owner   <= w_winner;
                r_ptr     <= ~w_winner;
            end
            if ((r_state == c_ST_WAIT) && mul_resp_val) begin
                r_result <= mul_resp_msg;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)     w_state_next = c_ST_SEND;
            c_ST_SEND: if (mul_req_rdy)  w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (mul_resp_val) w_state_next = c_ST_RESP;
            c_ST_RESP: if (r_owner ? resp1_rdy : resp0_rdy) w_state_next = c_ST_IDLE;
            default:                     w_state_next = c_ST_IDLE;
        endcase
    end

    // Request-ready is gated by reset so nothing is offered while held in reset
    always_comb begin
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                req0_rdy = reset & w_grant[0];
                req1_rdy = reset & w_grant[1];
            end
            c_ST_SEND: mul_req_val  = 1'b1;
            c_ST_WAIT: mul_resp_rdy = 1'b1;
            c_ST_RESP: begin
                resp0_val = ~r_owner;
                resp1_val =  r_owner;
            end
            default: ;
        endcase
    end

    assign mul_req_msg = r_operand;
    assign resp0_msg   = r_result;
    assign resp1_msg   = r_result;
    assign busy        = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lab1_imul_mul_arbiter.sv
// ============================================================================
// Module  : tb_lab1_imul_mul_arbiter
// Brief   : Directed self-checking bench with a behavioural multiplier model
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_lab1_imul_mul_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic [63:0] req0_msg;
    logic [31:0] resp0_msg;
    logic        req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic [63:0] req1_msg;
    logic [31:0] resp1_msg;
    logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic [63:0] mul_req_msg;
    logic [31:0] mul_resp_msg;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lab1_imul_mul_arbiter #(.p_nbits(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: holds rdy low for mul_stall cycles, answers after mul_lat cycles
    int          mul_stall = 0;
    int          mul_lat   = 1;
    int          sv_cnt;
    int          m_cnt;
    logic        m_busy;
    logic [31:0] m_res;

    assign mul_req_rdy  = !m_busy && (sv_cnt >= mul_stall);
    assign mul_resp_val = m_busy && (m_cnt == 0);
    assign mul_resp_msg = m_res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            sv_cnt <= 0;
            m_res  <= '0;
        end else begin
            if (mul_req_val && mul_req_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= mul_lat - 1;
                m_res  <= mul_req_msg[63:32] * mul_req_msg[31:0];
                sv_cnt <= 0;
            end else if (mul_req_val) begin
                sv_cnt <= sv_cnt + 1;
            end
            if (m_busy && m_cnt != 0) m_cnt <= m_cnt - 1;
            if (mul_resp_val && mul_resp_rdy) m_busy <= 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        checks++;
        if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy, busy});
        end
        checks++;
        if (resp0_msg !== 32'd0 || mul_req_msg !== 64'd0) begin
            errors++;
            $display("FAIL reset_regs: resp=%h op=%h expected 0", resp0_msg, mul_req_msg);
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b rdy0=%b rdy1=%b expected 0", busy, req0_rdy, req1_rdy);
        end
    endtask

    task automatic test_single();
        int cyc = 0;
        bit seen1 = 0;
        @(negedge clk);
        req0_msg = {32'd3, 32'd4};
        req0_val = 1'b1;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        #1;
        checks++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: rdy0=%b rdy1=%b expected 1 0", req0_rdy, req1_rdy);
        end
        do begin
            @(negedge clk);
            req0_val = 1'b0;
            #1;
            cyc++;
            if (resp1_val) seen1 = 1;
        end while (!resp0_val && cyc < 30);
        checks++;
        if (resp0_val !== 1'b1 || cyc != 3) begin
            errors++;
            $display("FAIL single_latency: val=%b cycles=%0d expected 1 after 3", resp0_val, cyc);
        end
        checks++;
        if (resp0_msg !== 32'h0000000C) begin
            errors++;
            $display("FAIL single_data: got %h expected 0000000c", resp0_msg);
        end
        checks++;
        if (seen1) begin
            errors++;
            $display("FAIL single_resp1: resp1_val=1 seen expected never");
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_both();
        int cyc = 0;
        bit r1bad = 0;
        do_reset();
        req0_msg = {32'd7, 32'd6};
        req1_msg = {32'd5, 32'd5};
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        checks++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL both_first_grant: rdy0=%b rdy1=%b expected 1 0", req0_rdy, req1_rdy);
        end
        do begin
            @(negedge clk);
            req0_val = 1'b0;
            #1;
            cyc++;
            if (req1_rdy) r1bad = 1;
        end while (!resp0_val && cyc < 30);
        checks++;
        if (resp0_val !== 1'b1 || resp0_msg !== 32'd42) begin
            errors++;
            $display("FAIL both_resp0: val=%b data=%0d expected 1 42", resp0_val, resp0_msg);
        end
        checks++;
        if (r1bad) begin
            errors++;
            $display("FAIL both_req1_blocked: req1_rdy=1 during port0 txn expected 0");
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_rdy !== 1'b1) begin
            errors++;
            $display("FAIL both_second_grant: rdy1=%b expected 1", req1_rdy);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            req1_val = 1'b0;
            #1;
            cyc++;
        end while (!resp1_val && cyc < 30);
        checks++;
        if (resp1_val !== 1'b1 || resp1_msg !== 32'd25) begin
            errors++;
            $display("FAIL both_resp1: val=%b data=%0d expected 1 25", resp1_val, resp1_msg);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int order[6];
        int n = 0;
        int cyc = 0;
        bit bad_both = 0;
        bit bad_data = 0;
        req0_msg = {32'd2, 32'd3};
        req1_msg = {32'd4, 32'd5};
        req0_val = 1'b1;
        req1_val = 1'b1;
        for (int c = 0; c < 300 && n < 6; c++) begin
            #1;
            if (req0_rdy && req1_rdy) bad_both = 1;
            if (req0_rdy) begin
                order[n] = 0;
                n++;
            end else if (req1_rdy) begin
                order[n] = 1;
                n++;
            end
            if (resp0_val && resp0_msg !== 32'd6)  bad_data = 1;
            if (resp1_val && resp1_msg !== 32'd20) bad_data = 1;
            @(negedge clk);
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
            if (resp0_val && resp0_msg !== 32'd6)  bad_data = 1;
            if (resp1_val && resp1_msg !== 32'd20) bad_data = 1;
        end while (busy && cyc < 50);
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL fair_count: grants=%0d expected 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                errors++;
                $display("FAIL fair_order[%0d]: port=%0d expected %0d", i, order[i], i % 2);
            end
        end
        checks++;
        if (bad_both || bad_data) begin
            errors++;
            $display("FAIL fair_data: both_rdy=%b bad_data=%b expected 0 0", bad_both, bad_data);
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        @(negedge clk);
        req1_msg = {32'hFFFFFFFD, 32'd5};
        req1_val = 1'b1;
        resp1_rdy = 1'b0;
        do begin
            @(negedge clk);
            req1_val = 1'b0;
            #1;
            cyc++;
        end while (!resp1_val && cyc < 30);
        checks++;
        if (resp1_val !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp: resp1_val=%b expected 1", resp1_val);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp1_val !== 1'b1 || resp1_msg !== 32'hFFFFFFF1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: val=%b data=%h busy=%b expected 1 fffffff1 1",
                         i, resp1_val, resp1_msg, busy);
            end
        end
        resp1_rdy = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || resp1_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b val=%b expected 0 0", busy, resp1_val);
        end
    endtask

    task automatic test_stall();
        int cyc = 0;
        int stalls = 0;
        int waitc = 0;
        bit msgbad = 0;
        @(negedge clk);
        mul_stall = 3;
        mul_lat = 10;
        req0_msg = {32'hFFFFFFFF, 32'd2};
        req0_val = 1'b1;
        resp0_rdy = 1'b1;
        do begin
            @(negedge clk);
            req0_val = 1'b0;
            #1;
            cyc++;
            if (mul_req_val) begin
                if (mul_req_msg !== 64'hFFFFFFFF_00000002) msgbad = 1;
                if (!mul_req_rdy) stalls++;
            end
            if (mul_resp_rdy) waitc++;
        end while (!resp0_val && cyc < 100);
        checks++;
        if (resp0_val !== 1'b1 || resp0_msg !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL stall_data: val=%b data=%h expected 1 fffffffe", resp0_val, resp0_msg);
        end
        checks++;
        if (msgbad || stalls != 3) begin
            errors++;
            $display("FAIL stall_send: msg_unstable=%b stalls=%0d expected 0 3", msgbad, stalls);
        end
        checks++;
        if (waitc != 10) begin
            errors++;
            $display("FAIL stall_wait: wait_cycles=%0d expected 10", waitc);
        end
        mul_stall = 0;
        mul_lat = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        @(negedge clk);
        mul_lat = 10;
        req0_msg = {32'd1, 32'd1};
        req0_val = 1'b1;
        do begin
            @(negedge clk);
            req0_val = 1'b0;
            #1;
            cyc++;
        end while (!mul_resp_rdy && cyc < 30);
        checks++;
        if (mul_resp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_wait: mul_resp_rdy=%b expected 1", mul_resp_rdy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy, busy} !== 7'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got %b expected 0000000",
                     {req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        mul_lat = 1;
        req0_msg = {32'd3, 32'd3};
        req1_msg = {32'd2, 32'd9};
        req0_val = 1'b1;
        req1_val = 1'b1;
        #1;
        checks++;
        if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0 || resp1_msg !== 32'd0) begin
            errors++;
            $display("FAIL mid_ptr_reset: rdy0=%b rdy1=%b result=%h expected 1 0 0",
                     req0_rdy, req1_rdy, resp1_msg);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            req0_val = 1'b0;
            #1;
            cyc++;
        end while (!resp0_val && cyc < 30);
        checks++;
        if (resp0_val !== 1'b1 || resp0_msg !== 32'd9) begin
            errors++;
            $display("FAIL mid_resp0: val=%b data=%0d expected 1 9", resp0_val, resp0_msg);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc > 0) req1_val = 1'b0;
            #1;
            cyc++;
        end while (!resp1_val && cyc < 30);
        checks++;
        if (resp1_val !== 1'b1 || resp1_msg !== 32'd18) begin
            errors++;
            $display("FAIL mid_resp1: val=%b data=%0d expected 1 18", resp1_val, resp1_msg);
        end
        req1_val = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        req0_msg = '0;
        req1_msg = '0;
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_fairness();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
